fifo_sync: RTL and testbench

Single-clock synchronous FIFO with parameterised depth and data width. It buffers write-side words and returns them in order on the read side. It flags empty and full, and reports the current occupancy count. It is a generic buffering block for any single-clock-domain producer/consumer pair.

---
 rtl/fifo_sync.sv | 66 ++++++
 tb/tb_fifo_sync.sv | 118 +++++++++++
 2 files changed

// File: rtl/fifo_sync.sv
// Single-clock synchronous FIFO: depth x width storage, registered read data,
// occupancy counter with empty/full decodes. Depth need not be a power of two.
module fifo_sync #(
   parameter int depth = 8,
   parameter int width = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              rd_en,
   input  logic                              wr_en,
   input  logic [width-1:0]                  data_in,
   output logic [width-1:0]                  data_out,
   output logic                              empty,
   output logic                              full,
   output logic [$clog2(depth):0]            counter_status
);

   function automatic int clog2f(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   localparam int AW = clog2f(depth);
   localparam logic [AW-1:0] LAST = AW'(depth - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(depth);

   logic [width-1:0] mem [depth];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_wr, do_rd;

   // Both requests are qualified against the flags as they stood before the edge.
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   assign empty          = (count == '0);
   assign full           = (count == FULL_CNT);
   assign counter_status = count;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         data_out <= '0;
      end else begin
         if (do_wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (do_rd) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed table-driven bench for fifo_sync (depth 8, width 8) plus hand-written
// asynchronous-reset sequences.
module tb_fifo_sync;

   logic       clk, rst, rd_en, wr_en;
   logic [7:0] data_in, data_out;
   logic       empty, full;
   logic [3:0] counter_status;

   int passed = 0;
   int total  = 0;

   fifo_sync #(.depth(8), .width(8)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .data_in(data_in),
      .data_out(data_out), .empty(empty), .full(full), .counter_status(counter_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] din;
      logic [7:0] dout;
      logic [3:0] cnt;
      logic       emp;
      logic       ful;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rd, input logic wr, input logic [7:0] din,
                      input logic [7:0] dout, input logic [3:0] cnt);
      vec_t v;
      v.rd = rd; v.wr = wr; v.din = din; v.dout = dout; v.cnt = cnt;
      v.emp = (cnt == 0);
      v.ful = (cnt == 8);
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_all(input string tag, input logic [7:0] dout, input logic [3:0] cnt,
                          input logic emp, input logic ful);
      chk({tag, " data_out"}, 32'(data_out), 32'(dout));
      chk({tag, " count"}, 32'(counter_status), 32'(cnt));
      chk({tag, " empty"}, 32'(empty), 32'(emp));
      chk({tag, " full"}, 32'(full), 32'(ful));
   endtask

   task automatic step(input logic rd, input logic wr, input logic [7:0] din);
      rd_en = rd; wr_en = wr; data_in = din;
      @(posedge clk);
      #1;
      rd_en = 1'b0; wr_en = 1'b0;
   endtask

   initial begin
      rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; data_in = '0;

      // basic order
      for (int i = 1; i <= 4; i++) add(0, 1, 8'(i), 8'd0, 4'(i));
      for (int i = 1; i <= 4; i++) add(1, 0, 8'd0, 8'(i), 4'(4 - i));
      // fill, overflow, wrap
      for (int i = 0; i < 8; i++) add(0, 1, 8'((i + 4) % 8 + 1), 8'd4, 4'(i + 1));
      add(0, 1, 8'd44, 8'd4, 4'd8);
      for (int i = 0; i < 8; i++) add(1, 0, 8'd0, 8'((i + 4) % 8 + 1), 4'(7 - i));
      // underflow
      add(1, 0, 8'd0, 8'd4, 4'd0);
      // concurrent traffic with one word stored
      add(0, 1, 8'd44, 8'd4, 4'd1);
      add(1, 1, 8'd10, 8'd44, 4'd1);
      add(1, 1, 8'd20, 8'd10, 4'd1);
      add(1, 1, 8'd30, 8'd20, 4'd1);
      add(1, 1, 8'd40, 8'd30, 4'd1);
      add(1, 0, 8'd0, 8'd40, 4'd0);
      // simultaneous when empty: write only, no bypass to data_out
      add(1, 1, 8'd55, 8'd40, 4'd1);
      for (int i = 0; i < 7; i++) add(0, 1, 8'(56 + i), 8'd40, 4'(i + 2));
      // simultaneous when full: read only, 99 dropped
      add(1, 1, 8'd99, 8'd55, 4'd7);
      for (int i = 0; i < 7; i++) add(1, 0, 8'd0, 8'(56 + i), 4'(6 - i));
      add(1, 0, 8'd0, 8'd62, 4'd0);

      // asynchronous reset, away from any clock edge
      #3 rst = 1'b1;
      #1 chk_all("reset", 8'd0, 4'd0, 1'b1, 1'b0);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
      begin
         step(vecs[i].rd, vecs[i].wr, vecs[i].din);
         chk_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].cnt, vecs[i].emp, vecs[i].ful);
      end

      // mid-operation reset with three words stored
      step(0, 1, 8'd1);
      step(0, 1, 8'd2);
      step(0, 1, 8'd3);
      chk("pre-reset count", 32'(counter_status), 32'd3);
      #2 rst = 1'b1;
      #1 chk_all("mid reset", 8'd0, 4'd0, 1'b1, 1'b0);
      #2 rst = 1'b0;
      step(0, 1, 8'd9);
      chk_all("post reset wr", 8'd0, 4'd1, 1'b0, 1'b0);
      step(1, 0, 8'd0);
      chk_all("post reset rd", 8'd9, 4'd0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
